// File: rtl/pwm_fade_ctrl.sv
// Duty sequencer for the display PWM: immediate set/off, timed fade to a target,
// and a repeating breathe cycle, all paced by a prescaled step tick.
module pwm_fade_ctrl #(
    parameter int DW         = 4,
    parameter int STEP_DIV   = 1200000,
    parameter int HOLD_STEPS = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic [DW-1:0] target,
    input  logic          stop,
    output logic [DW-1:0] duty,
    output logic          busy,
    output logic          done,
    output logic [2:0]    state
);

    localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(STEP_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_STEPS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RAMP    = 3'd1,
        UP      = 3'd2,
        HOLD_HI = 3'd3,
        DOWN    = 3'd4,
        HOLD_LO = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        CMD_SET     = 2'b00,
        CMD_FADE    = 2'b01,
        CMD_BREATHE = 2'b10,
        CMD_OFF     = 2'b11
    } cmd_e;

    state_e        state_q, state_d;
    logic [DW-1:0] duty_q, duty_d;
    logic [DW-1:0] tgt_q, tgt_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          done_q, done_d;
    logic          tick;

    // One step toward goal; the comparison comes first, so duty can never wrap.
    function automatic logic [DW-1:0] step_toward(input logic [DW-1:0] cur,
                                                  input logic [DW-1:0] goal);
        if (cur < goal)      return cur + 1'b1;
        else if (cur > goal) return cur - 1'b1;
        return cur;
    endfunction

    assign tick = (state_q != IDLE) && (pre_q == PRE_LAST);

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the case infers a latch.
        state_d = state_q;
        duty_d  = duty_q;
        tgt_d   = tgt_q;
        hold_d  = hold_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    case (cmd_e'(mode))
                        CMD_SET: begin
                            duty_d = target;
                            done_d = 1'b1;
                        end
                        CMD_OFF: begin
                            duty_d = '0;
                            done_d = 1'b1;
                        end
                        CMD_FADE: begin
                            tgt_d = target;
                            if (duty_q == target) done_d  = 1'b1;
                            else                  state_d = RAMP;
                        end
                        CMD_BREATHE: begin
                            tgt_d = target;
                            if (target == '0) begin
                                duty_d = '0;
                                done_d = 1'b1;
                            end else begin
                                state_d = UP;
                            end
                        end
                    endcase
                end
            end
            RAMP: begin
                if (tick) begin
                    duty_d = step_toward(duty_q, tgt_q);
                    if (duty_d == tgt_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            UP: begin
                if (tick) begin
                    duty_d = step_toward(duty_q, tgt_q);
                    if (duty_d == tgt_q) begin
                        state_d = HOLD_HI;
                        hold_d  = '0;
                    end
                end
            end
            DOWN: begin
                if (tick) begin
                    duty_d = step_toward(duty_q, '0);
                    if (duty_d == '0) begin
                        state_d = HOLD_LO;
                        hold_d  = '0;
                    end
                end
            end
            HOLD_HI, HOLD_LO: begin
                if (tick) begin
                    if (hold_q == HOLD_LAST) begin
                        hold_d  = '0;
                        state_d = (state_q == HOLD_HI) ? DOWN : UP;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort: freeze duty where it is and skip the done pulse.
        if (stop && state_q != IDLE) begin
            state_d = IDLE;
            duty_d  = duty_q;
            done_d  = 1'b0;
        end

        if (state_q == IDLE || state_d == IDLE) pre_d = '0;
        else if (pre_q == PRE_LAST)             pre_d = '0;
        else                                    pre_d = pre_q + 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            duty_q  <= '0;
            tgt_q   <= '0;
            pre_q   <= '0;
            hold_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            tgt_q   <= tgt_d;
            pre_q   <= pre_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
        end
    end

    assign duty  = duty_q;
    assign busy  = (state_q != IDLE);
    assign done  = done_q;
    assign state = state_q;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed bench for pwm_fade_ctrl with STEP_DIV=4, HOLD_STEPS=2: inputs change and
// outputs are sampled on the falling clock edge.
module tb_pwm_fade_ctrl;

    localparam int DW = 4;
    localparam logic [1:0] M_SET = 2'b00, M_FADE = 2'b01, M_BRTH = 2'b10, M_OFF = 2'b11;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [DW-1:0] target = '0;
    logic          stop = 1'b0;
    logic [DW-1:0] duty;
    logic          busy;
    logic          done;
    logic [2:0]    state;

    int errors = 0;
    int checks = 0;

    pwm_fade_ctrl #(.DW(DW), .STEP_DIV(4), .HOLD_STEPS(2)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .mode   (mode),
        .target (target),
        .stop   (stop),
        .duty   (duty),
        .busy   (busy),
        .done   (done),
        .state  (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Checks the full output set; busy must follow state.
    task automatic expect_out(input string tag, input int d, input int s, input int dn);
        check({tag, ".duty"}, int'(duty), d);
        check({tag, ".state"}, int'(state), s);
        check({tag, ".done"}, int'(done), dn);
        check({tag, ".busy"}, int'(busy), (s != 0) ? 1 : 0);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on a falling edge; returns on the falling edge after the accepting rising edge.
    task automatic cmd(input logic [1:0] m, input logic [DW-1:0] t);
        mode   = m;
        target = t;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    int brth_d[13] = '{1, 2, 2, 2, 1, 0, 0, 0, 1, 2, 2, 2, 1};
    int brth_s[13] = '{2, 3, 3, 4, 4, 5, 5, 2, 2, 3, 3, 4, 4};

    initial begin
        #1 reset = 1'b1;
        wait_cyc(2);
        expect_out("por", 0, 0, 0);
        reset = 1'b0;
        wait_cyc(1);
        expect_out("por_rel", 0, 0, 0);

        // SET: immediate, one-cycle done, never busy
        cmd(M_SET, 4'd9);
        expect_out("set9", 9, 0, 1);
        wait_cyc(1);
        expect_out("set9_after", 9, 0, 0);

        // OFF then FADE 0 -> 3, one step per 4 cycles
        cmd(M_OFF, 4'd7);
        expect_out("off", 0, 0, 1);
        wait_cyc(1);
        cmd(M_FADE, 4'd3);
        expect_out("fade3_k", 0, 1, 0);
        wait_cyc(3);
        expect_out("fade3_pre", 0, 1, 0);
        wait_cyc(1);
        expect_out("fade3_t1", 1, 1, 0);
        wait_cyc(4);
        expect_out("fade3_t2", 2, 1, 0);
        wait_cyc(4);
        expect_out("fade3_t3", 3, 0, 1);
        wait_cyc(1);
        expect_out("fade3_end", 3, 0, 0);
        cmd(M_FADE, 4'd3);
        expect_out("fade3_same", 3, 0, 1);
        wait_cyc(1);

        // start while RAMP ignored, stop aborts, start+stop in IDLE dropped
        cmd(M_FADE, 4'd10);
        expect_out("fade10_k", 3, 1, 0);
        mode = M_SET; target = 4'd0; start = 1'b1;
        wait_cyc(1);
        start = 1'b0;
        expect_out("start_in_ramp", 3, 1, 0);
        stop = 1'b1;
        wait_cyc(1);
        stop = 1'b0;
        expect_out("stop_ramp", 3, 0, 0);
        mode = M_SET; target = 4'd12; start = 1'b1; stop = 1'b1;
        wait_cyc(1);
        start = 1'b0; stop = 1'b0;
        expect_out("start_stop_idle", 3, 0, 0);
        wait_cyc(1);
        expect_out("start_stop_after", 3, 0, 0);

        // Boundaries: 14 -> 15 and 1 -> 0 in a single step, no wrap
        cmd(M_SET, 4'd14);
        wait_cyc(1);
        cmd(M_FADE, 4'd15);
        expect_out("fade15_k", 14, 1, 0);
        wait_cyc(4);
        expect_out("fade15_t1", 15, 0, 1);
        wait_cyc(4);
        expect_out("fade15_hold", 15, 0, 0);
        cmd(M_FADE, 4'd15);
        expect_out("fade15_same", 15, 0, 1);
        wait_cyc(1);
        cmd(M_SET, 4'd1);
        wait_cyc(1);
        cmd(M_FADE, 4'd0);
        expect_out("fade0_k", 1, 1, 0);
        wait_cyc(4);
        expect_out("fade0_t1", 0, 0, 1);
        wait_cyc(4);
        expect_out("fade0_hold", 0, 0, 0);

        // BREATHE peak=2, full loop then stop during DOWN
        cmd(M_BRTH, 4'd2);
        expect_out("brth_k", 0, 2, 0);
        for (int i = 0; i < 13; i++) begin
            wait_cyc(4);
            expect_out($sformatf("brth_t%0d", i + 1), brth_d[i], brth_s[i], 0);
        end
        stop = 1'b1;
        wait_cyc(1);
        stop = 1'b0;
        expect_out("brth_stop", 1, 0, 0);
        wait_cyc(1);
        expect_out("brth_stop_after", 1, 0, 0);

        // BREATHE with peak 0 acts as OFF
        cmd(M_BRTH, 4'd0);
        expect_out("brth0", 0, 0, 1);
        wait_cyc(1);

        // Asynchronous reset mid-breathe at duty 5
        cmd(M_BRTH, 4'd7);
        begin
            int n = 0;
            while (duty != 4'd5 && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        expect_out("brth7_at5", 5, 2, 0);
        #2 reset = 1'b1;
        #1 expect_out("rst_async", 0, 0, 0);
        wait_cyc(2);
        reset = 1'b0;
        wait_cyc(6);
        expect_out("rst_after", 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
